// File: rtl/cache_way_burst_if.sv
// ---------------------------------------------------------------------------
// cache_way_burst_if
// Groups every signal between the cache way and its two neighbours: the L1
// controller (lookup/store requests and commands) and the memory side
// (fill beats in, writeback beats out).
//   master : the controller / memory side (drives requests, fill beats, wb_ready)
//   slave  : the cache way (drives lookup status, writeback beats, busy/done)
// ---------------------------------------------------------------------------
interface cache_way_burst_if #(
    parameter int OFFSET_WIDTH = 3,
    parameter int INDEX_WIDTH  = 7,
    parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH
);
    // lookup / store request
    logic                    req_en;
    logic                    req_write;
    logic [3:0]              req_byte_en;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_word;
    logic [31:0]             req_data;
    // lookup status
    logic                    hit;
    logic                    valid;
    logic                    dirty;
    logic [TAG_WIDTH-1:0]    tag_out;
    logic [31:0]             data_out;
    // refill
    logic                    fill_start;
    logic [TAG_WIDTH-1:0]    fill_tag;
    logic                    fill_valid;
    logic [31:0]             fill_data;
    // writeback
    logic                    wb_start;
    logic                    wb_valid;
    logic                    wb_ready;
    logic [31:0]             wb_data;
    logic                    wb_last;
    logic [TAG_WIDTH-1:0]    wb_tag;
    // sweep and command status
    logic                    flush_start;
    logic                    busy;
    logic                    done;

    modport master (
        output req_en, req_write, req_byte_en, req_tag, req_index, req_word, req_data,
        output fill_start, fill_tag, fill_valid, fill_data,
        output wb_start, wb_ready, flush_start,
        input  hit, valid, dirty, tag_out, data_out,
        input  wb_valid, wb_data, wb_last, wb_tag, busy, done
    );

    modport slave (
        input  req_en, req_write, req_byte_en, req_tag, req_index, req_word, req_data,
        input  fill_start, fill_tag, fill_valid, fill_data,
        input  wb_start, wb_ready, flush_start,
        output hit, valid, dirty, tag_out, data_out,
        output wb_valid, wb_data, wb_last, wb_tag, busy, done
    );
endinterface

// File: rtl/cache_way_burst.sv
// ---------------------------------------------------------------------------
// cache_way_burst
// One cache way (DEPTH lines of WORDS 32-bit words) with a line-transfer
// engine: combinational lookup, byte-enabled store on hit, wrapping
// critical-word-first refill, handshaked writeback and, when the macro
// CACHE_WAY_FLUSH_EN is defined, a whole-way invalidate sweep.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (clears valid/dirty, FSM, counters)
//   bus    cache_way_burst_if.slave - requests, lookup status, fill beats,
//          writeback beats, busy and one-cycle done pulse
// Data and tag arrays are not reset.
// ---------------------------------------------------------------------------
module cache_way_burst #(
    parameter int OFFSET_WIDTH = 3,
    parameter int INDEX_WIDTH  = 7,
    parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_way_burst_if.slave  bus
);
    localparam int WORDS = 2 ** OFFSET_WIDTH;
    localparam int DEPTH = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WB   = 2'd2
`ifdef CACHE_WAY_FLUSH_EN
        , FLUSH = 2'd3
`endif
    } state_t;

    state_t state, state_nxt;

    logic [INDEX_WIDTH-1:0]  cur_idx;     // line owned by the running command
    logic [OFFSET_WIDTH-1:0] start_word;  // critical word of the refill
    logic [OFFSET_WIDTH-1:0] beat;        // beat counter, wraps modulo WORDS
    logic [TAG_WIDTH-1:0]    cap_tag;     // tag installed when the refill ends
    logic [DEPTH-1:0]        line_valid;
    logic [DEPTH-1:0]        line_dirty;
    logic                    done_q;
    logic                    done_nxt;
`ifdef CACHE_WAY_FLUSH_EN
    logic [INDEX_WIDTH-1:0]  sweep;
`endif

    logic [TAG_WIDTH-1:0] tag_mem  [DEPTH];
    logic [31:0]          data_mem [DEPTH][WORDS];

    logic                    idle, go_flush, go_wb, go_fill, do_store;
    logic                    look_hit, lookup_on;
    logic                    fill_beat, fill_last;
    logic                    wb_line_ok, wb_on, wb_fire, wb_last_fire;
    logic [OFFSET_WIDTH-1:0] fill_word;

    // ---------------- command decode ----------------
    assign idle = (state == IDLE);
`ifdef CACHE_WAY_FLUSH_EN
    assign go_flush = idle & bus.flush_start;
`else
    assign go_flush = 1'b0;
`endif
    assign go_wb    = idle & ~go_flush & bus.wb_start;
    assign go_fill  = idle & ~go_flush & ~bus.wb_start & bus.fill_start;

    assign look_hit = line_valid[bus.req_index] & (tag_mem[bus.req_index] == bus.req_tag);
    // a store only happens when no command start claims the cycle
    assign do_store = idle & ~go_flush & ~bus.wb_start & ~bus.fill_start &
                      bus.req_en & bus.req_write & look_hit;

    assign fill_beat = (state == FILL) & bus.fill_valid;
    assign fill_last = fill_beat & (&beat);
    assign fill_word = start_word + beat;  // wraps around the line

    // a line that is clean or invalid is skipped with no beats
    assign wb_line_ok   = line_valid[cur_idx] & line_dirty[cur_idx];
    assign wb_on        = (state == WB) & wb_line_ok;
    assign wb_fire      = wb_on & bus.wb_ready;
    assign wb_last_fire = wb_fire & (&beat);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go_flush)     state_nxt = state_t'(2'd3);
                else if (go_wb)   state_nxt = WB;
                else if (go_fill) state_nxt = FILL;
            end
            FILL:    if (fill_last) state_nxt = IDLE;
            WB:      if (!wb_line_ok || wb_last_fire) state_nxt = IDLE;
`ifdef CACHE_WAY_FLUSH_EN
            FLUSH:   if (&sweep) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
        done_nxt = (state != IDLE) && (state_nxt == IDLE);
    end

    // ---------------- control state and line status ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_idx    <= '0;
            start_word <= '0;
            beat       <= '0;
            cap_tag    <= '0;
            line_valid <= '0;
            line_dirty <= '0;
            done_q     <= 1'b0;
`ifdef CACHE_WAY_FLUSH_EN
            sweep      <= '0;
`endif
        end else begin
            done_q <= done_nxt;
            if (go_fill) begin
                cur_idx                <= bus.req_index;
                start_word             <= bus.req_word;
                cap_tag                <= bus.fill_tag;
                beat                   <= '0;
                line_valid[bus.req_index] <= 1'b0;
            end
            if (go_wb) begin
                cur_idx <= bus.req_index;
                beat    <= '0;
            end
            if (fill_beat || wb_fire) beat <= beat + 1'b1;
            if (fill_last) begin
                line_valid[cur_idx] <= 1'b1;
                line_dirty[cur_idx] <= 1'b0;
            end
            if (wb_last_fire) line_dirty[cur_idx] <= 1'b0;
            if (do_store) line_dirty[bus.req_index] <= 1'b1;
`ifdef CACHE_WAY_FLUSH_EN
            if (go_flush) sweep <= '0;
            if (state == FLUSH) begin
                line_valid[sweep] <= 1'b0;
                line_dirty[sweep] <= 1'b0;
                sweep             <= sweep + 1'b1;
            end
`endif
        end
    end

    // ---------------- arrays (no reset) ----------------
    always_ff @(posedge clk) begin
        if (fill_beat) begin
            data_mem[cur_idx][fill_word] <= bus.fill_data;
        end else if (do_store) begin
            for (int b = 0; b < 4; b++)
                if (bus.req_byte_en[b])
                    data_mem[bus.req_index][bus.req_word][8*b +: 8] <= bus.req_data[8*b +: 8];
        end
        if (fill_last) tag_mem[cur_idx] <= cap_tag;
    end

    // ---------------- outputs ----------------
    assign lookup_on    = idle & bus.req_en;
    assign bus.hit      = lookup_on & look_hit;
    assign bus.valid    = lookup_on & line_valid[bus.req_index];
    assign bus.dirty    = lookup_on & line_dirty[bus.req_index];
    assign bus.tag_out  = lookup_on ? tag_mem[bus.req_index] : '0;
    assign bus.data_out = lookup_on ? data_mem[bus.req_index][bus.req_word] : '0;

    // beat and last are driven from the registered counter, so they hold
    // steady while the sink stalls
    assign bus.wb_valid = wb_on;
    assign bus.wb_data  = wb_on ? data_mem[cur_idx][beat] : '0;
    assign bus.wb_last  = wb_on & (&beat);
    assign bus.wb_tag   = wb_on ? tag_mem[cur_idx] : '0;

    assign bus.busy = ~idle;
    assign bus.done = done_q;
endmodule

// File: tb/tb_cache_way_burst.sv
module tb_cache_way_burst;
    localparam int OW    = 3;
    localparam int IW    = 7;
    localparam int TW    = 30 - OW - IW;
    localparam int WORDS = 2 ** OW;
    localparam int DEPTH = 2 ** IW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_way_burst_if #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) ifc();
    cache_way_burst #(.OFFSET_WIDTH(OW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    int errors = 0;
    int checks = 0;

    // line-level model of the way
    bit [31:0]   m_data  [DEPTH][WORDS];
    bit [TW-1:0] m_tag   [DEPTH];
    bit          m_valid [DEPTH];
    bit          m_dirty [DEPTH];

    // expectations for the current cycle, set by the stimulus
    bit exp_busy, exp_done, exp_wbv, chk_en;
    int wb_idx, wb_k;
    logic [31:0] wbq[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin : cmp
        int i;
        int w;
        bit lk;
        if (chk_en) begin
            i  = int'(ifc.req_index);
            w  = int'(ifc.req_word);
            lk = !exp_busy && ifc.req_en;
            chk("busy", ifc.busy, exp_busy);
            chk("done", ifc.done, exp_done);
            chk("wb_valid", ifc.wb_valid, exp_wbv);
            if (exp_wbv) begin
                chk("wb_data", ifc.wb_data, m_data[wb_idx][wb_k]);
                chk("wb_last", ifc.wb_last, wb_k == WORDS - 1);
                chk("wb_tag", ifc.wb_tag, m_tag[wb_idx]);
            end else begin
                chk("wb_last_idle", ifc.wb_last, 0);
            end
            chk("hit", ifc.hit, lk && m_valid[i] && (m_tag[i] == ifc.req_tag));
            chk("valid", ifc.valid, lk && m_valid[i]);
            chk("dirty", ifc.dirty, lk && m_dirty[i]);
            if (lk && m_valid[i]) begin
                chk("tag_out", ifc.tag_out, m_tag[i]);
                chk("data_out", ifc.data_out, m_data[i][w]);
            end else if (!lk) begin
                chk("tag_out_off", ifc.tag_out, 0);
                chk("data_out_off", ifc.data_out, 0);
            end
            if (ifc.wb_valid && ifc.wb_ready) wbq.push_back(ifc.wb_data);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        exp_done = 1'b0;
    endtask

    task automatic clear_inputs();
        ifc.req_en = 0; ifc.req_write = 0; ifc.req_byte_en = 0; ifc.req_tag = 0;
        ifc.req_index = 0; ifc.req_word = 0; ifc.req_data = 0;
        ifc.fill_start = 0; ifc.fill_tag = 0; ifc.fill_valid = 0; ifc.fill_data = 0;
        ifc.wb_start = 0; ifc.wb_ready = 0; ifc.flush_start = 0;
    endtask

    task automatic set_lookup(int idx, int tag, int word);
        ifc.req_en = 1; ifc.req_write = 0;
        ifc.req_index = IW'(idx); ifc.req_tag = TW'(tag); ifc.req_word = OW'(word);
    endtask

    task automatic lookup(int idx, int tag, int word);
        set_lookup(idx, tag, word);
        cycle();
        ifc.req_en = 0;
    endtask

    task automatic store(int idx, int tag, int word, logic [3:0] be, logic [31:0] d);
        bit h;
        ifc.req_en = 1; ifc.req_write = 1; ifc.req_byte_en = be; ifc.req_data = d;
        ifc.req_index = IW'(idx); ifc.req_tag = TW'(tag); ifc.req_word = OW'(word);
        h = m_valid[idx] && (m_tag[idx] == TW'(tag));
        cycle();
        if (h) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_data[idx][word][8*b +: 8] = d[8*b +: 8];
            m_dirty[idx] = 1;
        end
        ifc.req_en = 0; ifc.req_write = 0;
    endtask

    // leaves the done cycle set up; caller ticks it
    task automatic fill(int idx, int tag, int start, logic [31:0] base, int gap_at);
        ifc.req_index = IW'(idx); ifc.fill_tag = TW'(tag); ifc.req_word = OW'(start);
        ifc.fill_start = 1;
        cycle();
        ifc.fill_start = 0; ifc.req_word = 0; ifc.fill_tag = 0;
        exp_busy = 1; m_valid[idx] = 0;
        for (int k = 0; k < WORDS; k++) begin
            if (k == gap_at) begin ifc.fill_valid = 0; cycle(); end
            ifc.fill_valid = 1; ifc.fill_data = base + k;
            cycle();
            m_data[idx][(start + k) % WORDS] = base + k;
        end
        ifc.fill_valid = 0;
        m_tag[idx] = TW'(tag); m_valid[idx] = 1; m_dirty[idx] = 0;
        exp_busy = 0; exp_done = 1;
    endtask

    task automatic writeback(int idx, bit inject_fill);
        ifc.req_index = IW'(idx); ifc.wb_start = 1;
        cycle();
        ifc.wb_start = 0; exp_busy = 1; wb_idx = idx; wb_k = 0;
        wbq.delete();
        if (!(m_valid[idx] && m_dirty[idx])) begin
            exp_wbv = 0;
            if (inject_fill) begin
                ifc.fill_start = 1; ifc.fill_tag = TW'(32'h3333); ifc.req_word = 3;
            end
            cycle();
            ifc.fill_start = 0;
        end else begin
            int n = 0;
            while (wb_k < WORDS) begin
                bit r;
                r = (n % 2 == 0);
                ifc.wb_ready = r; exp_wbv = 1;
                cycle();
                if (r) wb_k++;
                n++;
            end
            ifc.wb_ready = 0; exp_wbv = 0; m_dirty[idx] = 0;
        end
        exp_busy = 0; exp_done = 1;
    endtask

    initial begin
        logic [31:0] exp_beats [WORDS];
        exp_beats[0] = 32'h0000FFFF; exp_beats[1] = 32'hA3; exp_beats[2] = 32'hA4;
        exp_beats[3] = 32'hA5; exp_beats[4] = 32'hA6; exp_beats[5] = 32'hA7;
        exp_beats[6] = 32'hA0; exp_beats[7] = 32'hA1;

        clear_inputs();
        chk_en = 0; exp_busy = 0; exp_done = 0; exp_wbv = 0;
        #12;
        chk("rst_busy", ifc.busy, 0);
        chk("rst_done", ifc.done, 0);
        chk("rst_wb_valid", ifc.wb_valid, 0);
        chk("rst_wb_last", ifc.wb_last, 0);
        rst_n = 1;
        cycle();
        chk_en = 1;

        // lookup after reset misses
        set_lookup(5, 32'h1234, 0);
        #2;
        chk("t1_hit", ifc.hit, 0);
        chk("t1_valid", ifc.valid, 0);
        chk("t1_dirty", ifc.dirty, 0);
        cycle();
        ifc.req_en = 0;

        // wrapping refill from word 6, then lookup in the done cycle
        fill(5, 32'h1234, 6, 32'hA0, -1);
        set_lookup(5, 32'h1234, 0);
        #2;
        chk("t2_done", ifc.done, 1);
        chk("t2_hit", ifc.hit, 1);
        chk("t2_data_w0", ifc.data_out, 32'hA2);
        chk("t2_dirty", ifc.dirty, 0);
        cycle();
        ifc.req_en = 0;
        for (int w = 0; w < WORDS; w++) lookup(5, 32'h1234, w);

        // store miss leaves the line alone, store hit merges lanes
        store(5, 32'h1235, 1, 4'hF, 32'hDEADBEEF);
        lookup(5, 32'h1234, 1);
        store(5, 32'h1234, 0, 4'b0011, 32'hFFFFFFFF);
        set_lookup(5, 32'h1234, 0);
        #2;
        chk("t3_data", ifc.data_out, 32'h0000FFFF);
        chk("t3_dirty", ifc.dirty, 1);
        cycle();
        ifc.req_en = 0;

        // dirty writeback with stalls
        writeback(5, 0);
        chk("t4_beats", wbq.size(), WORDS);
        for (int k = 0; k < WORDS && k < wbq.size(); k++) chk($sformatf("t4_beat%0d", k), wbq[k], exp_beats[k]);
        set_lookup(5, 32'h1234, 0);
        #2;
        chk("t4_dirty", ifc.dirty, 0);
        chk("t4_valid", ifc.valid, 1);
        cycle();
        ifc.req_en = 0;

        // clean writeback: no beats; a fill_start while busy is ignored
        writeback(5, 1);
        cycle();
        lookup(5, 32'h1234, 7);
        chk("t5_beats", wbq.size(), 0);

`ifdef CACHE_WAY_FLUSH_EN
        fill(9, 32'h55, 0, 32'hB0, 3);
        cycle();
        fill(20, 32'h66, 5, 32'hC0, -1);
        ifc.flush_start = 1;
        cycle();
        ifc.flush_start = 0; exp_busy = 1;
        repeat (DEPTH) cycle();
        for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        exp_busy = 0; exp_done = 1;
        cycle();
        lookup(9, 32'h55, 0);
        set_lookup(20, 32'h66, 5);
        #2;
        chk("t6_flush_hit", ifc.hit, 0);
        cycle();
        ifc.req_en = 0;
`else
        // without the sweep feature flush_start does nothing
        ifc.flush_start = 1;
        cycle();
        ifc.flush_start = 0;
        cycle();
        set_lookup(5, 32'h1234, 0);
        #2;
        chk("t6_noflush_hit", ifc.hit, 1);
        cycle();
        ifc.req_en = 0;
`endif

        // reset in the middle of a refill
        ifc.req_index = 12; ifc.fill_tag = TW'(32'h77); ifc.req_word = 2; ifc.fill_start = 1;
        cycle();
        ifc.fill_start = 0; exp_busy = 1;
        for (int k = 0; k < 3; k++) begin
            ifc.fill_valid = 1; ifc.fill_data = 32'hE0 + k;
            cycle();
        end
        chk_en = 0;
        #1;
        rst_n = 0;
        #1;
        chk("t7_busy", ifc.busy, 0);
        chk("t7_done", ifc.done, 0);
        ifc.fill_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        exp_busy = 0; exp_done = 0;
        @(posedge clk);
        #3;
        rst_n = 1;
        cycle();
        chk_en = 1;
        repeat (3) cycle();
        lookup(12, 32'h77, 2);
        set_lookup(5, 32'h1234, 0);
        #2;
        chk("t7_valid5", ifc.valid, 0);
        cycle();
        ifc.req_en = 0;
        cycle();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
